// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and bit-mixing functions for the
// two-block SHA-256 compression engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Working variables a..h (also used for the hash state H0..H7, a == H0).
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } vars_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FOLD,
    DONE
  } fsm_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Upper-case sigma 0 (applied to a).
  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  // Upper-case sigma 1 (applied to e).
  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Lower-case sigma 0 (message schedule, W[t-15]).
  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Lower-case sigma 1 (message schedule, W[t-2]).
  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic vars_t init_vars();
    vars_t r;
    r.a = H_INIT[0];
    r.b = H_INIT[1];
    r.c = H_INIT[2];
    r.d = H_INIT[3];
    r.e = H_INIT[4];
    r.f = H_INIT[5];
    r.g = H_INIT[6];
    r.h = H_INIT[7];
    return r;
  endfunction

  // Word-wise mod 2^32 sum used by the fold step.
  function automatic vars_t vars_add(vars_t x, vars_t y);
    vars_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_2blk_core_if.sv
// sha256_2blk_core_if: message-in / digest-out valid/ready handshakes.
// Signal suffixes are from the core's point of view.
interface sha256_2blk_core_if;
  logic          in_valid_i;
  logic [1023:0] in_i;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [255:0]  out_o;
  logic          out_ready_i;

  modport master (
    output in_valid_i, in_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_o
  );

  modport slave (
    input  in_valid_i, in_i, out_ready_i,
    output in_ready_o, out_valid_o, out_o
  );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  vars_t v,
  input  word_t kt,
  input  word_t wt,
  output vars_t v_n
);

  word_t t1;
  word_t t2;

  // Round temporaries and the rotated working variables.
  always_comb begin
    t1      = v.h + bsig1(v.e) + ch(v.e, v.f, v.g) + kt + wt;
    t2      = bsig0(v.a) + maj(v.a, v.b, v.c);
    v_n     = v;
    v_n.a   = t1 + t2;
    v_n.b   = v.a;
    v_n.c   = v.b;
    v_n.d   = v.c;
    v_n.e   = v.d + t1;
    v_n.f   = v.e;
    v_n.g   = v.f;
    v_n.h   = v.g;
  end

endmodule

// File: rtl/sha256_2blk_core.sv
// sha256_2blk_core: iterative SHA-256 engine hashing one pre-padded
// 1024-bit (two-block) message per transaction.
// Build option SHA256_CORE_UNROLL2_EN: two chained rounds per cycle.
module sha256_2blk_core
  import sha256_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  sha256_2blk_core_if.slave bus
);

`ifdef SHA256_CORE_UNROLL2_EN
  localparam logic [5:0] CNT_STEP = 6'd2;
`else
  localparam logic [5:0] CNT_STEP = 6'd1;
`endif
  // Counter value of the final ROUND cycle of a block (63, or 62 unrolled).
  localparam logic [5:0] CNT_LAST = 6'd63 - CNT_STEP + 6'd1;

  fsm_t        state_q;
  fsm_t        state_d;
  vars_t       h_q;
  vars_t       v_q;
  vars_t       h_sum;
  vars_t       rnd_v;
  vars_t       rnd0_v;
  word_t       w_q [16];
  word_t       w_new0;
  logic [511:0] blk1_q;
  logic [5:0]  cnt_q;
  logic        blk_idx_q;
  logic        accept;
  logic        last_round;

  assign accept     = bus.in_ready_o & bus.in_valid_i;
  assign last_round = (cnt_q == CNT_LAST);
  assign h_sum      = vars_add(h_q, v_q);

  assign bus.in_ready_o  = rst_ni & (state_q == IDLE);
  assign bus.out_valid_o = rst_ni & (state_q == DONE);
  assign bus.out_o       = bus.out_valid_o ? h_q : '0;

  // Schedule word entering the window after W[t] is consumed.
  assign w_new0 = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

  sha256_round u_round0 (
    .v   (v_q),
    .kt  (K[cnt_q]),
    .wt  (w_q[0]),
    .v_n (rnd0_v)
  );

`ifdef SHA256_CORE_UNROLL2_EN
  vars_t rnd1_v;
  word_t w_new1;

  // Second word does not depend on w_new0 (its t-2 tap is still in the window).
  assign w_new1 = ssig1(w_q[15]) + w_q[10] + ssig0(w_q[2]) + w_q[1];

  sha256_round u_round1 (
    .v   (rnd0_v),
    .kt  (K[{cnt_q[5:1], 1'b1}]),
    .wt  (w_q[1]),
    .v_n (rnd1_v)
  );

  assign rnd_v = rnd1_v;
`else
  assign rnd_v = rnd0_v;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: in_valid only matters in IDLE, out_ready only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_round) state_d = FOLD;
      FOLD:    state_d = blk_idx_q ? DONE : ROUND;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hash state, working variables, round counter and block index.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q       <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
      blk_idx_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            h_q       <= init_vars();
            v_q       <= init_vars();
            cnt_q     <= '0;
            blk_idx_q <= 1'b0;
          end
        end
        ROUND: begin
          v_q   <= rnd_v;
          cnt_q <= cnt_q + CNT_STEP;
        end
        FOLD: begin
          h_q   <= h_sum;
          cnt_q <= '0;
          if (!blk_idx_q) begin
            v_q       <= h_sum;
            blk_idx_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Message schedule window; block 0 goes straight into the window on
  // accept and only block 1 is held for the second pass.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      blk1_q <= bus.in_i[511:0];
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= bus.in_i[1023 - 32*i -: 32];
      end
    end else if (state_q == ROUND) begin
`ifdef SHA256_CORE_UNROLL2_EN
      for (int i = 0; i < 14; i++) begin
        w_q[i] <= w_q[i + 2];
      end
      w_q[14] <= w_new0;
      w_q[15] <= w_new1;
`else
      for (int i = 0; i < 15; i++) begin
        w_q[i] <= w_q[i + 1];
      end
      w_q[15] <= w_new0;
`endif
    end else if ((state_q == FOLD) && !blk_idx_q) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= blk1_q[511 - 32*i -: 32];
      end
    end
  end

endmodule

// File: doc/sha256_2blk_core.md
# sha256_2blk_core

Iterative SHA-256 compression engine that accepts one pre-padded 1024-bit message (exactly two 512-bit blocks) over a valid/ready handshake and returns the 256-bit digest over a second valid/ready handshake. It is the responder behind the HMAC sequencer: the sequencer builds the padded inner and outer messages, and this core hashes them one at a time. Padding is never applied here; the caller supplies fully padded blocks.

## Interface
- No parameters.
- clk_i  input  1  rising-edge clock.
- rst_ni  input  1  synchronous reset, active low.
- in_valid_i  input  1  the caller has a message on in_i.
- in_i  input  1024  padded message, big-endian. in_i[1023:512] is block 0; in_i[511:0] is block 1.
- in_ready_o  output  1  the core can accept a message.
- out_valid_o  output  1  the digest on out_o is valid.
- out_o  output  256  digest H0..H7, H0 in bits [255:224].
- out_ready_i  input  1  the caller takes the digest.

## Operation
- States:
  - IDLE: in_ready_o=1.
  - ROUND: one SHA-256 round per cycle, round counter 0..63.
  - FOLD: Hk += working variable, then select the next block.
  - DONE: out_valid_o=1.
- IDLE → ROUND when in_valid_i & in_ready_o at a rising edge (accept). On accept:
  - in_i is captured into an internal 1024-bit block register; the caller may change in_i afterwards.
  - H is loaded with the FIPS 180-4 initial values.
  - a..h = H initial values; block index = 0.
- ROUND:
  - The message schedule is a 16-word shift window seeded from the current block.
  - Wt for t≥16 = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, mod 2^32.
  - All additions wrap mod 2^32.
  - After round 63 → FOLD.
- FOLD:
  - If block index = 0: H += a..h, a..h reload from the updated H, block index = 1, window reloads from block 1 → ROUND.
  - If block index = 1: H += a..h → DONE.
- DONE: out_o = H, held stable while out_valid_o=1. Advance to IDLE on out_valid_o & out_ready_i.
- in_valid_i is ignored outside IDLE. out_ready_i is ignored outside DONE.
- Reset (rst_ni low at an edge, in any state):
  - state = IDLE, out_valid_o=0, out_o=0, H/a..h/counter cleared.
  - in_ready_o is forced to 0 while rst_ni is low.
  - A hash in flight is discarded with no output.

## Timing
- Reset values while rst_ni is low: in_ready_o=0, out_valid_o=0, out_o=0.
- in_ready_o=1 in the first cycle after rst_ni goes high.
- Accept edge is E. Block 0 rounds occur at E+1..E+64, fold at E+65. Block 1 rounds occur at E+66..E+129, fold at E+130.
- out_valid_o is high in the cycle after E+130 (latency 130 edges).
- Output handshake edge is D. in_ready_o=1 in the cycle after D. There is no same-cycle turnaround and no overlap of messages.
- Minimum accept-to-accept interval is 132 cycles.

## Configuration
- SHA256_CORE_UNROLL2_EN:
  - Defined: two chained rounds per cycle, and the counter steps by 2 (0..62).
  - Each block takes 32 ROUND cycles plus 1 FOLD cycle, so out_valid_o rises after E+66.
  - The schedule window advances two words per cycle.
- Undefined: one round per cycle, timing as above.
- Digest results are identical in both builds.

## Structure
- Package sha256_pkg holds:
  - the 64-entry K constant array and the 8-word H initial-value array;
  - the state enum {IDLE, ROUND, FOLD, DONE};
  - functions ch, maj, Σ0, Σ1, σ0, σ1;
  - a word typedef (logic [31:0]).
- Sub-module sha256_round is combinational: inputs a..h, Kt, Wt; outputs the next a..h. It is instantiated once, or twice chained when SHA256_CORE_UNROLL2_EN is defined.
- The schedule window and the FSM stay in sha256_2blk_core.

## Test plan
- Known answer:
  - Stimulus: the 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded (0x80, zeros, length 64'h1C0), accepted while in_ready_o=1.
  - Required: out_o = 248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, with out_valid_o rising exactly 130 edges after accept (66 with the macro defined).
- Backpressure:
  - Stimulus: hold out_ready_i=0 for 20 cycles after out_valid_o rises.
  - Required: out_o is unchanged, out_valid_o stays 1 and in_ready_o stays 0. After out_ready_i pulses, in_ready_o=1 on the next cycle.
- Input capture: drive in_i to all-ones one cycle after accept. The known-answer digest is unchanged.
- Reset mid-operation:
  - Stimulus: pull rst_ni low at round 30 of block 1.
  - Required: out_valid_o never asserts for that message, in_ready_o=0 during reset and 1 the cycle after release. A following known-answer message returns the correct digest.
- Back-to-back: issue two known-answer messages with in_valid_i held high and out_ready_i held high. Two correct digests result, with accepts 132 cycles apart.
- Ignored inputs:
  - Stimulus: toggle in_valid_i during ROUND, and out_ready_i during ROUND and IDLE.
  - Required: no state change, no extra accept and no spurious output.
